alu_stim_seq: RTL and testbench

//  Operand/command driver for the ALU register-load interface: the initiator side of the
//  sw-data + load-strobe protocol. Drives the data bus, ld_a/ld_b/ld_r strobes and func_sel.

---
 rtl/alu_stim_pkg.sv | 36 +++
 rtl/alu_stim_seq_if.sv | 26 ++
 rtl/alu_dwell_cnt.sv | 32 +++
 rtl/alu_stim_seq.sv | 128 ++++++++++++
 tb/tb_alu_stim_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_stim_pkg.sv
// Shared encodings and defaults for the ALU operand/command sequencer.
package alu_stim_pkg;

  localparam int FUNC_W    = 4;
  localparam int DWELL_DEF = 4;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_SET_A = 4'd1;
  localparam logic [3:0] ST_LD_A  = 4'd2;
  localparam logic [3:0] ST_SET_B = 4'd3;
  localparam logic [3:0] ST_LD_B  = 4'd4;
  localparam logic [3:0] ST_SET_F = 4'd5;
  localparam logic [3:0] ST_LD_R  = 4'd6;
  localparam logic [3:0] ST_CAPT  = 4'd7;
  localparam logic [3:0] ST_RSP   = 4'd8;
  localparam logic [3:0] ST_DONE  = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_SET_A = ST_SET_A,
    S_LD_A  = ST_LD_A,
    S_SET_B = ST_SET_B,
    S_LD_B  = ST_LD_B,
    S_SET_F = ST_SET_F,
    S_LD_R  = ST_LD_R,
    S_CAPT  = ST_CAPT,
    S_RSP   = ST_RSP,
    S_DONE  = ST_DONE
  } state_e;

  // States that hold the bus stable for a full dwell period
  function automatic logic is_dwell(input state_e s);
    return (s == S_SET_A) || (s == S_SET_B) || (s == S_SET_F) || (s == S_CAPT);
  endfunction

endpackage

// File: rtl/alu_stim_seq_if.sv
// ALU register-load bus plus valid/ready response channel.
interface alu_stim_seq_if #(parameter int WIDTH = 4);
  import alu_stim_pkg::*;

  logic [WIDTH-1:0]  data_out;
  logic              ld_a;
  logic              ld_b;
  logic              ld_r;
  logic [FUNC_W-1:0] func_sel;
  logic [WIDTH:0]    result_in;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [FUNC_W-1:0] rsp_func;
  logic [WIDTH:0]    rsp_data;

  modport master (
    output data_out, ld_a, ld_b, ld_r, func_sel, rsp_valid, rsp_func, rsp_data,
    input  result_in, rsp_ready
  );

  modport slave (
    input  data_out, ld_a, ld_b, ld_r, func_sel, rsp_valid, rsp_func, rsp_data,
    output result_in, rsp_ready
  );

endinterface

// File: rtl/alu_dwell_cnt.sv
// Loadable down-counter; tc is high once DWELL cycles have elapsed since load.
module alu_dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(DWELL + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(DWELL - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/alu_stim_seq.sv
// Drives A/B/func and load strobes into an ALU, sweeping every func code and returning
// each result over valid/ready. Optional ALU_STIM_AUTOINC_EN: endless sweeps with A/B stepping.
module alu_stim_seq
  import alu_stim_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NUM_FUNC = 16,
  parameter int DWELL    = DWELL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_seed,
  input  logic [WIDTH-1:0] b_seed,
  output logic             busy,
  output logic             done,
  alu_stim_seq_if.master   bus
);

  localparam logic [FUNC_W-1:0] LAST_FUNC = FUNC_W'(NUM_FUNC - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, data_q, data_d;
  logic [FUNC_W-1:0] func_q, func_d, rsp_func_q, rsp_func_d;
  logic [WIDTH:0]    rsp_dat_q, rsp_dat_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              cnt_load, cnt_en, cnt_tc;

  alu_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    func_d     = func_q;
    rsp_func_d = rsp_func_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_vld_d  = rsp_vld_q;
    case (state_q)
      S_IDLE: if (start) begin
        a_d     = a_seed;
        b_d     = b_seed;
        data_d  = a_seed;
        func_d  = '0;
        state_d = S_SET_A;
      end
      S_SET_A: if (cnt_tc) state_d = S_LD_A;
      S_LD_A: begin
        data_d  = b_q;
        state_d = S_SET_B;
      end
      S_SET_B: if (cnt_tc) state_d = S_LD_B;
      S_LD_B:  state_d = S_SET_F;
      S_SET_F: if (cnt_tc) state_d = S_LD_R;
      S_LD_R:  state_d = S_CAPT;
      S_CAPT: if (cnt_tc) begin
        rsp_dat_d  = bus.result_in;
        rsp_func_d = func_q;
        rsp_vld_d  = 1'b1;
        state_d    = S_RSP;
      end
      S_RSP: if (bus.rsp_ready) begin
        rsp_vld_d = 1'b0;
        if (func_q == LAST_FUNC) begin
`ifdef ALU_STIM_AUTOINC_EN
          a_d     = a_q + 1'b1;
          if (&a_q) b_d = b_q + 1'b1;
          data_d  = a_q + 1'b1;
          func_d  = '0;
          state_d = S_SET_A;
`else
          state_d = S_DONE;
`endif
        end else begin
          func_d  = func_q + 1'b1;
          state_d = S_SET_F;
        end
      end
      // Sweep restarts only after start has been seen low
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_load = is_dwell(state_d) && (state_d != state_q);
  assign cnt_en   = is_dwell(state_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      data_q     <= '0;
      func_q     <= '0;
      rsp_func_q <= '0;
      rsp_dat_q  <= '0;
      rsp_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      data_q     <= data_d;
      func_q     <= func_d;
      rsp_func_q <= rsp_func_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_vld_q  <= rsp_vld_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.func_sel  = func_q;
  assign bus.ld_a      = (state_q == S_LD_A);
  assign bus.ld_b      = (state_q == S_LD_B);
  assign bus.ld_r      = (state_q == S_LD_R);
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_func  = rsp_func_q;
  assign bus.rsp_data  = rsp_dat_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_stim_seq.sv
// Bench for alu_stim_seq: table of sweeps against a small ALU model, plus reset/autoinc sequences.
module tb_alu_stim_seq;

  localparam int WIDTH    = 4;
  localparam int NUM_FUNC = 16;
  localparam int DWELL    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_seed = '0;
  logic [WIDTH-1:0] b_seed = '0;
  logic             busy, done;

  alu_stim_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_stim_seq #(.WIDTH(WIDTH), .NUM_FUNC(NUM_FUNC), .DWELL(DWELL)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_seed (a_seed),
    .b_seed (b_seed),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ALU model: result = A + B + func, 5-bit wrap
  logic [3:0] a_reg, b_reg;
  logic [4:0] r_reg;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0; b_reg <= '0; r_reg <= '0;
    end else begin
      if (bus.ld_a) a_reg <= bus.data_out;
      if (bus.ld_b) b_reg <= bus.data_out;
      if (bus.ld_r) r_reg <= {1'b0, a_reg} + {1'b0, b_reg} + {1'b0, bus.func_sel};
    end
  end
  assign bus.result_in = r_reg;

  // Strobe monitor: exclusivity, spacing, dwell before each strobe, operand on the bus
  logic [WIDTH-1:0] exp_a = '0, exp_b = '0;
  logic [7:0]       prev_bus = '0;
  logic [2:0]       strb;
  int               quiet = 0;
  bit               prev_strb = 0;
  int               ldr_cnt = 0, strb_cnt = 0;
  bit               done_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      quiet = 0;
      prev_strb = 0;
    end else begin
      strb = {bus.ld_a, bus.ld_b, bus.ld_r};
      if (strb != 3'b000) begin
        strb_cnt++;
        if (bus.ld_r) ldr_cnt++;
        check("strobe_onehot", $countones(strb), 1);
        check("strobe_gap", int'(prev_strb), 0);
        check("dwell_before_strobe", quiet, DWELL);
        if (bus.ld_a) check("ld_a_data", int'(bus.data_out), int'(exp_a));
        if (bus.ld_b) check("ld_b_data", int'(bus.data_out), int'(exp_b));
        quiet = 0;
      end else if (!busy) begin
        quiet = 0;
      end else if ({bus.data_out, bus.func_sel} != prev_bus) begin
        quiet = 1;
      end else begin
        quiet++;
      end
      prev_bus  = {bus.data_out, bus.func_sel};
      prev_strb = (strb != 3'b000);
      if (done) done_seen = 1;
    end
  end

  function automatic int all_outs();
    return int'({bus.data_out, bus.func_sel, bus.ld_a, bus.ld_b, bus.ld_r,
                 bus.rsp_valid, bus.rsp_func, bus.rsp_data, busy, done});
  endfunction

  // Collects one sweep of responses; optionally stalls rsp_ready at one func code
  task automatic collect(input int sum, input int stall_func, input int stall_len);
    for (int f = 0; f < NUM_FUNC; f++) begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.rsp_valid && n < 600);
      check("rsp_valid_seen", int'(bus.rsp_valid), 1);
      if (!bus.rsp_valid) return;
      check("rsp_func", int'(bus.rsp_func), f);
      check("rsp_data", int'(bus.rsp_data), (sum + f) % 32);
      if (f == stall_func) begin
        logic [4:0] hd = bus.rsp_data;
        logic [3:0] hf = bus.rsp_func;
        int l0 = ldr_cnt;
        bit stable = 1;
        repeat (stall_len) begin
          @(negedge clk);
          if (!bus.rsp_valid || bus.rsp_data != hd || bus.rsp_func != hf) stable = 0;
        end
        check("stall_rsp_stable", int'(stable), 1);
        check("stall_no_ld_r", ldr_cnt - l0, 0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      check("rsp_valid_drop", int'(bus.rsp_valid), 0);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         sum;
    bit         hold_start;
    int         stall_func;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 4'd3,  b: 4'd5,  sum: 8,  hold_start: 1'b0, stall_func: -1};
    vecs[1] = '{a: 4'd15, b: 4'd15, sum: 30, hold_start: 1'b0, stall_func: 2};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  sum: 0,  hold_start: 1'b1, stall_func: -1};
    vecs[3] = '{a: 4'd9,  b: 4'd12, sum: 21, hold_start: 1'b0, stall_func: -1};

    bus.rsp_ready = 1'b0;
    #3 check("reset_outputs", all_outs(), 0);
    #20 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", int'({busy, done}), 0);

    // Reset during SET_F of func 3
    begin
      int n = 0;
      a_seed = 4'd6; b_seed = 4'd9; exp_a = 4'd6; exp_b = 4'd9;
      bus.rsp_ready = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.func_sel != 4'd3 && n < 600);
      check("reach_func3", int'(bus.func_sel), 3);
      @(negedge clk);
      check("pre_reset_rsp_data", int'(bus.rsp_data), 17);
      #2 rst = 1'b0;
      #1 check("mid_sweep_reset_outputs", all_outs(), 0);
      bus.rsp_ready = 1'b0;
      #10 rst = 1'b1;
      n = strb_cnt;
      repeat (30) @(negedge clk);
      check("no_strobe_after_reset", strb_cnt - n, 0);
      check("idle_after_mid_reset", int'(busy), 0);
    end

`ifdef ALU_STIM_AUTOINC_EN
    @(negedge clk);
    a_seed = 4'd15; b_seed = 4'd2; exp_a = 4'd15; exp_b = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    collect(17, -1, 0);
    check("autoinc_no_done", int'(done), 0);
    check("autoinc_busy", int'(busy), 1);
    exp_a = 4'd0; exp_b = 4'd3;
    collect(3, -1, 0);
    check("autoinc_done_never", int'(done_seen), 0);
    rst = 1'b0;
    #7 rst = 1'b1;
`else
    for (int i = 0; i < 4; i++) begin
      int l0;
      @(negedge clk);
      a_seed = vecs[i].a; b_seed = vecs[i].b;
      exp_a = vecs[i].a;  exp_b = vecs[i].b;
      l0 = ldr_cnt;
      start = 1'b1;
      @(posedge clk);
      #1 check("busy_after_start", int'(busy), 1);
      if (!vecs[i].hold_start) start = 1'b0;
      collect(vecs[i].sum, vecs[i].stall_func, 50);
      check("done_after_sweep", int'(done), 1);
      check("busy_in_done", int'(busy), 0);
      check("ld_r_count", ldr_cnt - l0, NUM_FUNC);
      if (vecs[i].hold_start) begin
        repeat (5) @(negedge clk);
        check("done_held_with_start", int'(done), 1);
        start = 1'b0;
      end
      @(posedge clk);
      #1 check("idle_after_done", int'({busy, done}), 0);
    end
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
